// File: rtl/alu_seq_4bit.sv
// Sequential 4-bit ALU: add/sub in one cycle, shift-add multiply and restoring divide in four.
// Define ALU_DIV_EN to build the divider; otherwise a divide request completes with err=1.
module alu_seq_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dataIn,
    input  logic       loadA,
    input  logic       loadB,
    input  logic       selAdd,
    input  logic       selSub,
    input  logic       selMul,
    input  logic       selDiv,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [3:0] remainder,
    output logic       neg,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        ADDSUB,
        MUL,
`ifdef ALU_DIV_EN
        DIV,
`endif
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV
    } op_t;

    state_t     state, state_next;
    op_t        op, op_sel;
    logic [3:0] a, b;
    logic [1:0] cnt;
    logic [7:0] acc, acc_next, mcand;
    logic [3:0] mpl;

`ifdef ALU_DIV_EN
    logic [3:0] opb, quo, prem, quo_next, rem_next;
    logic [4:0] trial, diff;
    logic       ge;

    // One restoring-division step: bring in the next dividend bit, subtract if it fits
    always_comb begin
        trial    = {prem, quo[3]};
        diff     = trial - {1'b0, opb};
        ge       = (trial >= {1'b0, opb});
        rem_next = ge ? diff[3:0] : trial[3:0];
        quo_next = {quo[2:0], ge};
    end
`endif

    assign acc_next = acc + (mpl[0] ? mcand : 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        op_sel     = OP_ADD;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    priority case (1'b1)
                        selAdd: begin
                            op_sel     = OP_ADD;
                            state_next = ADDSUB;
                        end
                        selSub: begin
                            op_sel     = OP_SUB;
                            state_next = ADDSUB;
                        end
                        selMul: begin
                            op_sel     = OP_MUL;
                            state_next = MUL;
                        end
                        selDiv: begin
                            op_sel     = OP_DIV;
`ifdef ALU_DIV_EN
                            state_next = DIV;
`else
                            state_next = ADDSUB;
`endif
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end
            ADDSUB: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            MUL: begin
                busy = 1'b1;
                if (cnt == 2'd3) state_next = DONE;
            end
`ifdef ALU_DIV_EN
            DIV: begin
                busy = 1'b1;
                if (opb == 4'd0 || cnt == 2'd3) state_next = DONE;
            end
`endif
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a         <= 4'd0;
            b         <= 4'd0;
            op        <= OP_ADD;
            cnt       <= 2'd0;
            acc       <= 8'd0;
            mcand     <= 8'd0;
            mpl       <= 4'd0;
            result    <= 8'd0;
            remainder <= 4'd0;
            neg       <= 1'b0;
            err       <= 1'b0;
`ifdef ALU_DIV_EN
            opb       <= 4'd0;
            quo       <= 4'd0;
            prem      <= 4'd0;
`endif
        end else begin
            if ((state == IDLE || state == DONE) && loadA) a <= dataIn;
            if ((state == IDLE || state == DONE) && loadB) b <= dataIn;
            unique case (state)
                IDLE: begin
                    if (state_next != IDLE) begin
                        op    <= op_sel;
                        cnt   <= 2'd0;
                        acc   <= 8'd0;
                        mcand <= {4'd0, a};
                        mpl   <= b;
`ifdef ALU_DIV_EN
                        opb   <= b;
                        quo   <= a;
                        prem  <= 4'd0;
`endif
                    end
                end
                ADDSUB: begin
                    remainder <= 4'd0;
                    unique case (op)
                        OP_ADD: begin
                            result <= {4'd0, a} + {4'd0, b};
                            neg    <= 1'b0;
                            err    <= 1'b0;
                        end
                        OP_SUB: begin
                            result <= (a >= b) ? {4'd0, a - b} : {4'd0, b - a};
                            neg    <= (a < b);
                            err    <= 1'b0;
                        end
                        default: begin
                            result <= 8'hFF;
                            neg    <= 1'b0;
                            err    <= 1'b1;
                        end
                    endcase
                end
                MUL: begin
                    acc   <= acc_next;
                    mcand <= {mcand[6:0], 1'b0};
                    mpl   <= {1'b0, mpl[3:1]};
                    cnt   <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        result    <= acc_next;
                        remainder <= 4'd0;
                        neg       <= 1'b0;
                        err       <= 1'b0;
                    end
                end
`ifdef ALU_DIV_EN
                DIV: begin
                    if (opb == 4'd0) begin
                        result    <= 8'hFF;
                        remainder <= 4'd0;
                        neg       <= 1'b0;
                        err       <= 1'b1;
                    end else begin
                        quo  <= quo_next;
                        prem <= rem_next;
                        cnt  <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            result    <= {4'd0, quo_next};
                            remainder <= rem_next;
                            neg       <= 1'b0;
                            err       <= 1'b0;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_4bit.sv
// Directed-vector bench for alu_seq_4bit, with corner-case sequences for
// busy-time input blocking, reset abort and start with no select.
module tb_alu_seq_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dataIn;
    logic       loadA, loadB;
    logic       selAdd, selSub, selMul, selDiv;
    logic       start;
    logic       busy, done;
    logic [7:0] result;
    logic [3:0] remainder;
    logic       neg, err;

    int n_vec  = 0;
    int n_fail = 0;

`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    alu_seq_4bit dut (
        .clk       (clk),
        .rst       (rst),
        .dataIn    (dataIn),
        .loadA     (loadA),
        .loadB     (loadB),
        .selAdd    (selAdd),
        .selSub    (selSub),
        .selMul    (selMul),
        .selDiv    (selDiv),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .remainder (remainder),
        .neg       (neg),
        .err       (err)
    );

    always #5 clk = ~clk;

    // sel bits: [3]=add [2]=sub [1]=mul [0]=div
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sel;
        logic [7:0] res;
        logic [3:0] rem;
        logic       neg;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_ab(input logic [3:0] a, input logic [3:0] b);
        dataIn = a;
        loadA  = 1'b1;
        step();
        loadA  = 1'b0;
        dataIn = b;
        loadB  = 1'b1;
        step();
        loadB  = 1'b0;
    endtask

    task automatic set_sel(input logic [3:0] sel);
        {selAdd, selSub, selMul, selDiv} = sel;
    endtask

    // Count busy cycles from the start edge until done, bounded
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 20) begin
            if (busy) cyc++;
            step();
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int cyc;
        load_ab(v.a, v.b);
        set_sel(v.sel);
        start = 1'b1;
        step();
        start = 1'b0;
        set_sel(4'b0000);
        wait_done(cyc);
        check($sformatf("v%0d done", i), done, 1);
        check($sformatf("v%0d latency", i), cyc, v.lat);
        check($sformatf("v%0d result", i), result, v.res);
        check($sformatf("v%0d remainder", i), remainder, v.rem);
        check($sformatf("v%0d neg", i), neg, v.neg);
        check($sformatf("v%0d err", i), err, v.err);
        step();
        check($sformatf("v%0d done width", i), done, 0);
        check($sformatf("v%0d hold", i), result, v.res);
    endtask

    initial begin
        int cyc;
        vecs[0]  = '{4'd9,  4'd7,  4'b1000, 8'h10, 4'd0, 1'b0, 1'b0, 1};
        vecs[1]  = '{4'd3,  4'd9,  4'b0100, 8'h06, 4'd0, 1'b1, 1'b0, 1};
        vecs[2]  = '{4'd9,  4'd3,  4'b0100, 8'h06, 4'd0, 1'b0, 1'b0, 1};
        vecs[3]  = '{4'd15, 4'd15, 4'b0010, 8'hE1, 4'd0, 1'b0, 1'b0, 4};
        vecs[4]  = '{4'd6,  4'd5,  4'b0010, 8'h1E, 4'd0, 1'b0, 1'b0, 4};
        vecs[5]  = '{4'd0,  4'd9,  4'b0010, 8'h00, 4'd0, 1'b0, 1'b0, 4};
        vecs[6]  = '{4'd15, 4'd15, 4'b1000, 8'h1E, 4'd0, 1'b0, 1'b0, 1};
        vecs[7]  = '{4'd2,  4'd3,  4'b1010, 8'h05, 4'd0, 1'b0, 1'b0, 1};
        vecs[8]  = '{4'd2,  4'd3,  4'b0101, 8'h01, 4'd0, 1'b1, 1'b0, 1};
        vecs[9]  = '{4'd13, 4'd0,  4'b0001, 8'hFF, 4'd0, 1'b0, 1'b1, 1};
        if (DIV_EN) begin
            vecs[10] = '{4'd13, 4'd4, 4'b0001, 8'h03, 4'd1, 1'b0, 1'b0, 4};
            vecs[11] = '{4'd7,  4'd7, 4'b0001, 8'h01, 4'd0, 1'b0, 1'b0, 4};
        end else begin
            vecs[10] = '{4'd13, 4'd4, 4'b0001, 8'hFF, 4'd0, 1'b0, 1'b1, 1};
            vecs[11] = '{4'd7,  4'd7, 4'b0001, 8'hFF, 4'd0, 1'b0, 1'b1, 1};
        end

        rst    = 1'b1;
        dataIn = 4'd0;
        loadA  = 1'b0;
        loadB  = 1'b0;
        start  = 1'b0;
        set_sel(4'b0000);
        step();
        step();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        check("reset remainder", remainder, 0);
        check("reset neg", neg, 0);
        check("reset err", err, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Start with no select line stays idle
        start = 1'b1;
        step();
        start = 1'b0;
        check("nosel busy", busy, 0);
        step();
        check("nosel done", done, 0);

        // Start and loadA while multiplying are ignored
        load_ab(4'd15, 4'd15);
        set_sel(4'b0010);
        start = 1'b1;
        step();
        set_sel(4'b1000);
        dataIn = 4'd0;
        loadA  = 1'b1;
        step();
        step();
        start = 1'b0;
        loadA = 1'b0;
        set_sel(4'b0000);
        step();
        step();
        check("mulblk done", done, 1);
        check("mulblk result", result, 8'hE1);
        step();
        check("mulblk restart", busy, 0);
        set_sel(4'b1000);
        start = 1'b1;
        step();
        start = 1'b0;
        set_sel(4'b0000);
        wait_done(cyc);
        check("mulblk A kept", result, 8'h1E);
        step();

        // Reset in the second busy cycle of a multiply aborts it
        load_ab(4'd6, 4'd5);
        set_sel(4'b0010);
        start = 1'b1;
        step();
        start = 1'b0;
        set_sel(4'b0000);
        step();
        check("abort busy before", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort result", result, 0);
        check("abort remainder", remainder, 0);
        check("abort neg", neg, 0);
        check("abort err", err, 0);
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy) cyc++;
            step();
        end
        check("abort no done", cyc, 0);
        load_ab(4'd2, 4'd2);
        set_sel(4'b1000);
        start = 1'b1;
        step();
        start = 1'b0;
        set_sel(4'b0000);
        wait_done(cyc);
        check("post-abort add", result, 8'h04);
        check("post-abort lat", cyc, 1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
